// File: rtl/irq_pkg.sv
// Shared helpers and width derivations for the interrupt request queue.
package irq_pkg;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Source ID width: at least one bit, even for a single source.
  function automatic int sbits(input int nsrc);
    return (nsrc > 1) ? clog2(nsrc) : 1;
  endfunction

  // One FIFO entry is {source ID, payload}.
  function automatic int entry_w(input int nsrc, input int dbits);
    return sbits(nsrc) + dbits;
  endfunction

endpackage

// File: rtl/irq_rr_arbiter.sv
// Round-robin arbiter over the per-source busy vector. Grants at most one
// source per cycle when enabled.
module irq_rr_arbiter
  import irq_pkg::*;
#(
  parameter  int NSRC  = 4,
  localparam int SBITS = sbits(NSRC)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [NSRC-1:0]  i_req,
  input  logic             i_en,
  output logic [NSRC-1:0]  o_gnt,
  output logic [SBITS-1:0] o_idx,
  output logic             o_vld
);

  // r_ptr holds the search start, i.e. last_grant+1 modulo NSRC. Keeping the
  // start rather than the last winner lets a reset value of 0 mean source 0
  // has first priority after reset.
  logic [SBITS-1:0] r_ptr;
  int               w_c;

  // Scan NSRC positions starting at r_ptr; first requester wins.
  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_vld = 1'b0;
    w_c   = 0;
    for (int k = 0; k < NSRC; k++) begin
      w_c = (int'(r_ptr) + k) % NSRC;
      if (i_en && !o_vld && i_req[w_c]) begin
        o_vld      = 1'b1;
        o_gnt[w_c] = 1'b1;
        o_idx      = SBITS'(w_c);
      end
    end
  end

  // Advance the search start past the winner.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      r_ptr <= '0;
    else if (o_vld)
      r_ptr <= (int'(o_idx) == NSRC - 1) ? '0 : o_idx + 1'b1;
  end

endmodule

// File: rtl/irq_queue.sv
// Multi-source interrupt request queue: per-source holding registers drained
// round-robin into one shared first-word-fall-through FIFO.
module irq_queue
  import irq_pkg::*;
#(
  parameter  int ABITS = 4,
  parameter  int DBITS = 32,
  parameter  int NSRC  = 4,
  localparam int SBITS = sbits(NSRC),
  localparam int EW    = entry_w(NSRC, DBITS),
  localparam int DEPTH = 1 << ABITS
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [NSRC-1:0]       req,
  input  logic [NSRC*DBITS-1:0] req_data,
  output logic [NSRC-1:0]       busy,
  input  logic                  rd,
  output logic [DBITS-1:0]      dout,
  output logic [SBITS-1:0]      dout_src,
  output logic                  empty,
  output logic                  full,
  output logic [ABITS:0]        count,
  output logic [NSRC-1:0]       drop,
  input  logic [NSRC-1:0]       drop_clr
);

  logic [NSRC-1:0]  r_busy;
  logic [NSRC-1:0]  r_drop;
  logic [DBITS-1:0] r_hold [NSRC];
  logic [EW-1:0]    r_mem  [DEPTH];
  logic [ABITS:0]   r_wr_ptr;
  logic [ABITS:0]   r_rd_ptr;

  logic [ABITS:0]   w_count;
  logic             w_empty;
  logic             w_full;
  logic             w_pop;
  logic             w_push_ok;
  logic [NSRC-1:0]  w_gnt;
  logic [SBITS-1:0] w_idx;
  logic             w_vld;
  logic [NSRC-1:0]  w_refill;
  logic [EW-1:0]    w_head;

  // Occupancy and flags come straight from the pointer difference.
  assign w_count   = r_wr_ptr - r_rd_ptr;
  assign w_empty   = (w_count == '0);
  assign w_full    = (w_count == (ABITS+1)'(DEPTH));
  assign w_pop     = rd && !w_empty;
  // A pop in the same cycle frees the slot a full FIFO needs for the push.
  assign w_push_ok = !w_full || w_pop;

  irq_rr_arbiter #(.NSRC(NSRC)) u_arb (
    .clock   (clock),
    .reset_n (reset_n),
    .i_req   (r_busy),
    .i_en    (w_push_ok),
    .o_gnt   (w_gnt),
    .o_idx   (w_idx),
    .o_vld   (w_vld)
  );

  // A holding register accepts a new request when empty or when it is being
  // drained this very cycle; otherwise the request is lost and flagged.
  assign w_refill = req & (~r_busy | w_gnt);

  // Busy and sticky drop flags; a new drop beats drop_clr.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_busy <= '0;
      r_drop <= '0;
    end else begin
      r_busy <= w_refill | (r_busy & ~w_gnt);
      r_drop <= (req & r_busy & ~w_gnt) | (r_drop & ~drop_clr);
    end
  end

  // Payload capture; contents are qualified by busy so need no reset.
  always_ff @(posedge clock) begin
    for (int i = 0; i < NSRC; i++)
      if (w_refill[i]) r_hold[i] <= req_data[i*DBITS +: DBITS];
  end

  // FIFO storage write on grant; plain RAM, no reset.
  always_ff @(posedge clock) begin
    if (w_vld) r_mem[r_wr_ptr[ABITS-1:0]] <= {w_idx, r_hold[w_idx]};
  end

  // Read/write pointers wrap naturally at ABITS+1 bits.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_vld) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Fall-through head, forced to zero when there is nothing to show.
  assign w_head   = r_mem[r_rd_ptr[ABITS-1:0]];
  assign dout     = w_empty ? '0 : w_head[DBITS-1:0];
  assign dout_src = w_empty ? '0 : w_head[EW-1:DBITS];
  assign empty    = w_empty;
  assign full     = w_full;
  assign count    = w_count;
  assign busy     = r_busy;
  assign drop     = r_drop;

endmodule

// File: tb/tb_irq_queue.sv
// Directed and model-checked bench for irq_queue (ABITS=2, NSRC=4).
module tb_irq_queue;
  import irq_pkg::*;

  localparam int ABITS = 2;
  localparam int DBITS = 32;
  localparam int NSRC  = 4;
  localparam int DEPTH = 4;

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic [NSRC-1:0]   req = '0;
  logic [NSRC*DBITS-1:0] req_data = '0;
  logic [NSRC-1:0]   busy;
  logic              rd = 1'b0;
  logic [DBITS-1:0]  dout;
  logic [1:0]        dout_src;
  logic              empty;
  logic              full;
  logic [ABITS:0]    count;
  logic [NSRC-1:0]   drop;
  logic [NSRC-1:0]   drop_clr = '0;

  int n_chk  = 0;
  int n_fail = 0;

  // model state for the random phase
  logic [NSRC-1:0]  mbusy;
  logic [NSRC-1:0]  mdrop;
  logic [DBITS-1:0] mhold [NSRC];
  int               mptr;
  logic [33:0]      q[$];

  irq_queue #(.ABITS(ABITS), .DBITS(DBITS), .NSRC(NSRC)) dut (
    .clock(clock), .reset_n(reset_n), .req(req), .req_data(req_data),
    .busy(busy), .rd(rd), .dout(dout), .dout_src(dout_src), .empty(empty),
    .full(full), .count(count), .drop(drop), .drop_clr(drop_clr)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    req = '0; rd = 1'b0; drop_clr = '0;
    reset_n = 1'b0;
    #3;
    reset_n = 1'b1;
    step();
  endtask

  task automatic set_data(input int i, input logic [31:0] v);
    req_data[i*DBITS +: DBITS] = v;
  endtask

  initial begin
    logic [NSRC-1:0] ob;
    logic            pop;
    int              g;
    int              c;

    // ---- reset state
    #12;
    chk("rst_busy",  busy, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full",  full, 0);
    chk("rst_count", count, 0);
    chk("rst_drop",  drop, 0);
    chk("rst_dout",  dout, 0);
    chk("rst_src",   dout_src, 0);
    reset_n = 1'b1;
    step();

    // ---- single request, 2-cycle latency, pop
    req = 4'b0001; set_data(0, 32'hDEADBEEF);
    step(); req = '0;
    chk("t1_busy", busy, 4'b0001);
    chk("t1_empty_pre", empty, 1);
    step();
    chk("t1_empty", empty, 0);
    chk("t1_dout", dout, 32'hDEADBEEF);
    chk("t1_src", dout_src, 0);
    chk("t1_count", count, 1);
    rd = 1'b1;
    step();
    chk("t1_pop_empty", empty, 1);
    chk("t1_pop_dout", dout, 0);
    step();
    chk("t1_rd_empty_cnt", count, 0);
    rd = 1'b0;

    // ---- simultaneous burst, round-robin order
    do_reset();
    req = 4'b1111;
    for (int i = 0; i < 4; i++) set_data(i, 32'h10 + i);
    step(); req = '0;
    chk("t2_busy", busy, 4'b1111);
    chk("t2_cnt0", count, 0);
    for (int k = 1; k <= 4; k++) begin
      step();
      chk("t2_cnt", count, k);
    end
    chk("t2_full", full, 1);
    rd = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("t2_src", dout_src, k);
      chk("t2_dout", dout, 32'h10 + k);
      step();
    end
    rd = 1'b0;
    chk("t2_drained", empty, 1);
    chk("t2_drop", drop, 0);
    req = 4'b1111;
    for (int i = 0; i < 4; i++) set_data(i, 32'h20 + i);
    step(); req = '0;
    repeat (4) step();
    chk("t3_full", full, 1);
    chk("t3_count", count, 4);
    chk("t3_head_src", dout_src, 0);
    chk("t3_head", dout, 32'h20);

    // ---- backpressure when full
    req = 4'b0100; set_data(2, 32'h99);
    step(); req = '0;
    chk("t3_bp_busy", busy, 4'b0100);
    chk("t3_bp_drop", drop, 0);
    step();
    chk("t3_bp_hold", busy, 4'b0100);
    chk("t3_bp_cnt", count, 4);
    rd = 1'b1;
    step(); rd = 1'b0;
    chk("t3_pp_cnt", count, 4);
    chk("t3_pp_busy", busy, 0);
    chk("t3_pp_src", dout_src, 1);
    chk("t3_pp_dout", dout, 32'h21);

    // ---- drop reporting
    req = 4'b0010; set_data(1, 32'h55);
    step();
    chk("t4_busy1", busy, 4'b0010);
    chk("t4_nodrop", drop, 0);
    set_data(1, 32'h66);
    step(); req = '0;
    chk("t4_drop", drop, 4'b0010);
    drop_clr = 4'b0010;
    step(); drop_clr = '0;
    chk("t4_clr", drop, 0);
    req = 4'b0010; drop_clr = 4'b0010;
    step(); req = '0; drop_clr = '0;
    chk("t4_set_wins", drop, 4'b0010);
    rd = 1'b1;
    step();
    chk("t4_d1", dout, 32'h22); chk("t4_c1", count, 4);
    step();
    chk("t4_d2", dout, 32'h23); chk("t4_c2", count, 3);
    step();
    chk("t4_d3", dout, 32'h99); chk("t4_s3", dout_src, 2);
    step();
    chk("t4_d4", dout, 32'h55); chk("t4_s4", dout_src, 1);
    step();
    chk("t4_empty", empty, 1);
    rd = 1'b0;

    // ---- random traffic against a reference model
    do_reset();
    mbusy = '0; mdrop = '0; mptr = 0; q.delete();
    for (int cyc = 0; cyc < 300; cyc++) begin
      for (int i = 0; i < NSRC; i++) begin
        req[i] = ($urandom_range(0, 9) < 3);
        set_data(i, $urandom);
        drop_clr[i] = ($urandom_range(0, 9) == 0);
      end
      rd = ($urandom_range(0, 9) < ((cyc < 150) ? 4 : 8));
      pop = rd && (q.size() > 0);
      g = -1;
      if (q.size() < DEPTH || pop)
        for (int k = 0; k < NSRC; k++) begin
          c = (mptr + k) % NSRC;
          if (g < 0 && mbusy[c]) g = c;
        end
      if (pop) void'(q.pop_front());
      if (g >= 0) begin
        q.push_back({g[1:0], mhold[g]});
        mptr = (g + 1) % NSRC;
      end
      ob = mbusy;
      for (int i = 0; i < NSRC; i++) begin
        if (req[i] && (!ob[i] || g == i)) begin
          mbusy[i] = 1'b1;
          mhold[i] = req_data[i*DBITS +: DBITS];
        end else if (g == i) mbusy[i] = 1'b0;
        if (req[i] && ob[i] && g != i) mdrop[i] = 1'b1;
        else if (drop_clr[i])          mdrop[i] = 1'b0;
      end
      step();
      chk("rnd_count", count, q.size());
      chk("rnd_empty", empty, q.size() == 0);
      chk("rnd_full",  full, q.size() == DEPTH);
      chk("rnd_busy",  busy, mbusy);
      chk("rnd_drop",  drop, mdrop);
      chk("rnd_dout",  dout, (q.size() > 0) ? {30'd0, q[0][31:0]} : 0);
      chk("rnd_src",   dout_src, (q.size() > 0) ? q[0][33:32] : 2'd0);
    end
    req = '0; rd = 1'b0; drop_clr = '0;

    // ---- asynchronous reset mid-traffic
    do_reset();
    req = 4'b0111;
    set_data(0, 32'hA0); set_data(1, 32'hA1); set_data(2, 32'hA2);
    step(); req = '0;
    step(); step();
    req = 4'b0101; set_data(0, 32'hB0); set_data(2, 32'hB2);
    step(); req = '0;
    chk("t6_pre_cnt", count, 3);
    chk("t6_pre_busy", busy, 4'b0101);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t6_busy", busy, 0);
    chk("t6_empty", empty, 1);
    chk("t6_count", count, 0);
    chk("t6_full", full, 0);
    chk("t6_dout", dout, 0);
    chk("t6_src", dout_src, 0);
    #1;
    reset_n = 1'b1;
    step();
    req = 4'b1000; set_data(3, 32'hC3);
    step(); req = '0;
    step();
    chk("t6_post_dout", dout, 32'hC3);
    chk("t6_post_src", dout_src, 3);
    chk("t6_post_cnt", count, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/irq_queue.md
# irq_queue

Multi-source interrupt request queue: up to NSRC peripherals post a DBITS-wide payload via single-cycle strobes, a round-robin arbiter drains per-source holding registers into one shared first-word-fall-through FIFO, and the CPU interrupt controller pops entries tagged with source ID. It replaces the single-port button-debounced IRQ FIFO and adds:
- correct full/empty and occupancy;
- lossless simultaneous requests;
- drop reporting.

## Interface
- ABITS, 4: FIFO depth = 2**ABITS entries (ABITS ≥ 1).
- DBITS, 32: payload width.
- NSRC, 4: number of request sources (1..16).
- SBITS (localparam): max(1, clog2(NSRC)).

Ports:
- clock  in  1  system clock, all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req  in  NSRC  per-source single-cycle request strobe.
- req_data  in  NSRC*DBITS  source i payload at [i*DBITS +: DBITS], sampled with req[i].
- busy  out  NSRC  source i holding register occupied.
- rd  in  1  pop head entry; ignored when empty.
- dout  out  DBITS  head payload; 0 when empty.
- dout_src  out  SBITS  head source ID; 0 when empty.
- empty  out  1  no entries.
- full  out  1  count == 2**ABITS.
- count  out  ABITS+1  occupancy.
- drop  out  NSRC  sticky: request lost on source i.
- drop_clr  in  NSRC  clear drop[i]; set wins if same cycle.

## Operation
- Reset values: busy=0, empty=1, full=0, count=0, drop=0, dout=0, dout_src=0; pointers and arbiter pointer 0.
- Capture:
  - req[i] with busy[i]=0: hold[i] <= req_data slice, busy[i] <= 1.
  - req[i] with busy[i]=1 and source i not granted this cycle: request discarded, drop[i] <= 1.
  - req[i] in the same cycle hold[i] is granted: hold refilled, no drop.
- Arbitration: round-robin over busy. Search starts at last_grant+1 and wraps modulo NSRC. At most one grant per cycle, only when push is allowed. On grant: write {i, hold[i]} at wr_ptr, clear busy[i], last_grant <= i.
- Push allowed when !full, or when full and a pop occurs the same cycle.
- Pop: rd && !empty advances rd_ptr.
- Simultaneous push+pop: count unchanged.
- Pointers: ABITS+1 bits, wrap naturally. full/empty/count are derived from the pointer difference; there is no separate flag state.
- Read on empty: no effect, no pointer movement.
- Write on full without pop: no grant; holds stay pending, so backpressure propagates to busy.
- Reset mid-operation: all entries and pending holds are discarded immediately (asynchronous).

## Timing
- req at cycle t → busy[i]=1 in t+1 → granted at end of t+1 (no contention) → empty=0, dout valid in t+2. Latency 2 cycles.
- Contention: with k sources busy, worst-case wait is NSRC-1 extra cycles.
- FWFT: dout/dout_src combinational from RAM at rd_ptr, masked to 0 when empty. After a pop at edge e, the next entry is visible immediately after e.
- Throughput: one push and one pop per cycle sustained.
- drop_clr takes effect on the next edge.

## Structure
- Package irq_pkg:
  - clog2 function;
  - SBITS derivation;
  - entry width constant (SBITS+DBITS).
- Sub-module irq_rr_arbiter:
  - parameter NSRC;
  - inputs request vector and enable;
  - outputs one-hot grant, encoded index, and valid;
  - owns the last_grant register.
- FIFO storage is an inferred RAM inside irq_queue (no reset on RAM contents).

## Test plan
- Reset, then single req[0] with data 0xDEADBEEF at cycle 1 → empty=0 at cycle 3, dout=0xDEADBEEF, dout_src=0, count=1; rd → empty=1, dout=0.
- NSRC=4: req=4'b1111 in one cycle, data 0x10..0x13 → entries pop in source order 0,1,2,3. Next burst after last_grant=3 again starts at 0; no drop.
- ABITS=2: fill 4 entries with no rd → full=1, count=4. Extra req on source 2 → busy[2] stays 1, no drop. Assert rd with full=1 → that same cycle the pending entry is pushed and count stays 4.
- req[1] twice in consecutive cycles while FIFO full → drop[1]=1. drop_clr[1] → drop[1]=0 next cycle. drop_clr and a new drop in the same cycle → drop[1] stays 1.
- Random push/pop with rd on empty and over pointer wrap (≥3×depth entries) → scoreboard order per source preserved; count matches model every cycle.
- Deassert reset_n mid-traffic with count=3 and busy=4'b0101 → outputs return to reset values asynchronously; first post-reset entry lands at address 0.
